// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the data-memory stage: instruction codes,
// access classes and the memory initiator's FSM state encoding.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } dmem_state_e;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } dmem_cls_e;

  typedef struct packed {
    dmem_cls_e   cls;
    logic [63:0] addr;
    logic [63:0] wdata;
  } dmem_access_t;

endpackage

// File: rtl/dmem_access_decode.sv
// Combinational decode of a Y86 icode into memory access class,
// address and write data for the memory stage.
module dmem_access_decode
  import y86_pkg::*;
(
  input  logic [3:0]   icode,
  input  logic [63:0]  val_a,
  input  logic [63:0]  val_e,
  input  logic [63:0]  val_p,
  output dmem_access_t access
);

  // Stack ops (ret/popq) address through valA, which holds the old %rsp.
  always_comb begin
    access = '0;
    case (icode)
      IRMMOVQ, IPUSHQ: begin
        access.cls   = ACC_WRITE;
        access.addr  = val_e;
        access.wdata = val_a;
      end
      IMRMOVQ: begin
        access.cls  = ACC_READ;
        access.addr = val_e;
      end
      ICALL: begin
        access.cls   = ACC_WRITE;
        access.addr  = val_e;
        access.wdata = val_p;
      end
      IRET, IPOPQ: begin
        access.cls  = ACC_READ;
        access.addr = val_a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_initiator.sv
// Y86 memory-stage initiator: issues one read/write per start to a
// req/gnt/rvalid responder. Define DMEM_TIMEOUT_EN to abort stalled accesses.
module dmem_initiator
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'd1023,
  parameter int          TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        done,
  output logic        busy,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  dmem_state_e  state, state_next;
  dmem_access_t dec;
  dmem_cls_e    cls_q;
  logic [63:0]  addr_q, wdata_q, valm_q;
  logic         error_q;
  logic         fault;
  logic         timeout_hit;

  dmem_access_decode u_decode (
    .icode  (icode),
    .val_a  (valA),
    .val_e  (valE),
    .val_p  (valP),
    .access (dec)
  );

  assign fault = (dec.cls != ACC_NONE) && (dec.addr > ADDR_LIMIT);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             in_flight;

  assign in_flight = (state == S_REQ) || (state == S_WAIT);

  // Counts cycles of the current access; restarts from zero on every new start.
  always_ff @(posedge clk) begin
    if (!rst_n)         tmo_cnt <= '0;
    else if (in_flight) tmo_cnt <= tmo_cnt + CNT_W'(1);
    else                tmo_cnt <= '0;
  end

  assign timeout_hit = in_flight && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (dec.cls == ACC_NONE || fault) ? S_DONE : S_REQ;
      S_REQ: begin
        if (mem_gnt)
          state_next = (cls_q == ACC_WRITE || mem_rvalid) ? S_DONE : S_WAIT;
        else if (timeout_hit)
          state_next = S_DONE;
      end
      S_WAIT: if (mem_rvalid || timeout_hit) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields are frozen at start so the pipeline may move on while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_q   <= ACC_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cls_q   <= dec.cls;
            addr_q  <= dec.addr;
            wdata_q <= dec.wdata;
            error_q <= fault;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            if (cls_q == ACC_READ && mem_rvalid) valm_q <= mem_rdata;
          end else if (timeout_hit) begin
            error_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid)       valm_q  <= mem_rdata;
          else if (timeout_hit) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    mem_req    = (state == S_REQ);
    mem_we     = (cls_q == ACC_WRITE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    valM       = valm_q;
    dmem_error = error_q;
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Self-checking bench for dmem_initiator: directed scenarios plus randomized
// transactions against a transaction-level model. Timeout case needs DMEM_TIMEOUT_EN.
module tb_dmem_initiator;

  localparam logic [63:0] LIMIT = 64'd1023;
  localparam int          TMO   = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic [63:0] valM;
  logic        done, busy, dmem_error;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_valm = '0;
  logic        exp_err  = 1'b0;

  dmem_initiator #(.ADDR_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .icode      (icode),
    .valA       (valA),
    .valE       (valE),
    .valP       (valP),
    .valM       (valM),
    .done       (done),
    .busy       (busy),
    .dmem_error (dmem_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level view of an instruction: kind 0 none, 1 read, 2 write.
  function automatic void ref_access(input logic [3:0] ic, input logic [63:0] a, e, p,
                                     output int kind, output logic [63:0] addr,
                                     output logic [63:0] data);
    kind = 0; addr = '0; data = '0;
    case (ic)
      4'd4:  begin kind = 2; addr = e; data = a; end
      4'd5:  begin kind = 1; addr = e; end
      4'd8:  begin kind = 2; addr = e; data = p; end
      4'd9:  begin kind = 1; addr = a; end
      4'd10: begin kind = 2; addr = e; data = a; end
      4'd11: begin kind = 1; addr = a; end
      default: ;
    endcase
  endfunction

  // Changes pipeline inputs while busy; a well-behaved initiator must ignore them.
  task automatic drive_noise();
    start = 1'($urandom_range(0, 1));
    icode = 4'($urandom_range(0, 15));
    valA  = {$urandom, $urandom};
    valE  = {$urandom, $urandom};
    valP  = {$urandom, $urandom};
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_req"},  mem_req, 1'b0);
    checkOutput({tag, "_err"},  dmem_error, exp_err);
    checkOutput({tag, "_valM"}, valM, exp_valm);
  endtask

  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] a, e, p,
                               input int gnt_dly, input int rv_dly,
                               input logic [63:0] rdata, input bit noise);
    int          kind;
    logic [63:0] ea, ed;
    bit          flt;
    ref_access(ic, a, e, p, kind, ea, ed);
    flt = (kind != 0) && (ea > LIMIT);
    start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
    mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata  = {$urandom, $urandom};
    step();
    start = 1'b0; mem_rvalid = 1'b0;
    if (kind == 0 || flt) begin
      exp_err = flt;
      checkOutput("short_done", done, 1'b1);
      checkOutput("short_busy", busy, 1'b1);
      checkOutput("short_req",  mem_req, 1'b0);
      checkOutput("short_err",  dmem_error, exp_err);
      checkOutput("short_valM", valM, exp_valm);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        checkOutput("req_req",  mem_req, 1'b1);
        checkOutput("req_busy", busy, 1'b1);
        checkOutput("req_done", done, 1'b0);
        checkOutput("req_we",   mem_we, (kind == 2));
        checkOutput("req_addr", mem_addr, ea);
        if (kind == 2) checkOutput("req_wdata", mem_wdata, ed);
        if (noise) drive_noise();
        mem_gnt    = (i == gnt_dly);
        mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata  = {$urandom, $urandom};
        if (i == gnt_dly && kind == 1) begin
          mem_rvalid = (rv_dly == 0);
          mem_rdata  = rdata;
        end
        step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (kind == 1) begin
        for (int j = 1; j <= rv_dly; j++) begin
          checkOutput("wait_busy", busy, 1'b1);
          checkOutput("wait_req",  mem_req, 1'b0);
          checkOutput("wait_done", done, 1'b0);
          if (noise) drive_noise();
          mem_rvalid = (j == rv_dly);
          mem_rdata  = (j == rv_dly) ? rdata : {$urandom, $urandom};
          step();
        end
        mem_rvalid = 1'b0;
        exp_valm = rdata;
      end
      exp_err = 1'b0;
      checkOutput("fin_done", done, 1'b1);
      checkOutput("fin_busy", busy, 1'b1);
      checkOutput("fin_req",  mem_req, 1'b0);
      checkOutput("fin_err",  dmem_error, exp_err);
      checkOutput("fin_valM", valM, exp_valm);
    end
    start = 1'b0;
    step();
    checkIdle("post");
  endtask

  initial begin
    logic [63:0] cand [2];
    rst_n = 1'b0; start = 1'b0; icode = '0;
    valA = '0; valE = '0; valP = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    checkIdle("reset");
    checkOutput("reset_we",    mem_we, 1'b0);
    checkOutput("reset_addr",  mem_addr, 64'd0);
    checkOutput("reset_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;
    step();

    // rmmovq with immediate grant
    applyStimulus(4'd4, 64'hDEAD, 64'h40, 64'h0, 0, 0, 64'h0, 1'b0);
    // mrmovq, grant after 3 extra cycles, rvalid two cycles after grant
    applyStimulus(4'd5, 64'h0, 64'h10, 64'h0, 3, 2, 64'h1234, 1'b0);
    // popq from an out-of-range stack pointer
    applyStimulus(4'd11, 64'd2000, 64'h0, 64'h0, 0, 0, 64'h0, 1'b0);
    // address boundaries: highest legal, first illegal, top of 64-bit range
    applyStimulus(4'd9, 64'd1023, 64'h0, 64'h0, 0, 0, 64'hA5A5, 1'b0);
    applyStimulus(4'd10, 64'h77, 64'd1024, 64'h0, 0, 0, 64'h0, 1'b0);
    applyStimulus(4'd5, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, 64'h0, 1'b0);
    // no-access icode after a fault clears the error and keeps valM
    applyStimulus(4'd6, 64'h1, 64'h2, 64'h3, 0, 0, 64'h0, 1'b0);
    // call with a second start and operand churn while busy
    applyStimulus(4'd8, 64'h0, 64'h100, 64'hCAFE, 2, 0, 64'h0, 1'b1);

    // reset in the middle of a read's WAIT phase
    start = 1'b1; icode = 4'd5; valE = 64'h80;
    step();
    start = 1'b0;
    checkOutput("rst_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("rst_wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    exp_valm = '0; exp_err = 1'b0;
    checkIdle("rst_mid");
    checkOutput("rst_mid_we",    mem_we, 1'b0);
    checkOutput("rst_mid_addr",  mem_addr, 64'd0);
    checkOutput("rst_mid_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    step();
    mem_rvalid = 1'b0;
    checkIdle("rst_after");

`ifdef DMEM_TIMEOUT_EN
    // ret that is never granted
    start = 1'b1; icode = 4'd9; valA = 64'h30;
    step();
    start = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      checkOutput("tmo_req", mem_req, 1'b1);
      checkOutput("tmo_done_early", done, 1'b0);
      step();
    end
    exp_err = 1'b1;
    checkOutput("tmo_req_drop", mem_req, 1'b0);
    checkOutput("tmo_done", done, 1'b1);
    checkOutput("tmo_err",  dmem_error, 1'b1);
    checkOutput("tmo_valM", valM, exp_valm);
    step();
    checkIdle("tmo_post");
`endif

    // random transactions; latencies stay below the timeout budget
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0:       cand[k] = 64'($urandom_range(0, 1023));
          1:       cand[k] = LIMIT;
          2:       cand[k] = {$urandom, $urandom} | 64'h400;
          default: cand[k] = 64'($urandom_range(0, 255)) << 2;
        endcase
      end
      applyStimulus(4'($urandom_range(0, 15)), cand[0], cand[1], {$urandom, $urandom},
                    $urandom_range(0, 8), $urandom_range(0, 5), {$urandom, $urandom}, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
